// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, data width, default baud divider.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS        = 8;
    localparam int unsigned UART_BAUD_DIV_DEFAULT = 104;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Two-out-of-three vote used by the optional rx glitch filter.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// 2-FF synchronizer for the asynchronous rx pad, with an optional 3-tap majority
// filter selected by UART_RX_GLITCH_FILTER_EN.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rxs_c
);

    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

`ifdef UART_RX_GLITCH_FILTER_EN
    // Tap 0 is the synchronizer output itself, so the vote costs one extra cycle.
    logic [1:0] r_tap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tap <= 2'b11;
        end else begin
            r_tap <= {r_tap[0], r_sync[1]};
        end
    end

    assign o_rxs_c = maj3(r_sync[1], r_tap[0], r_tap[1]);
`else
    assign o_rxs_c = r_sync[1];
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, centre-sampled with a BAUD_DIV-cycle bit timer.
// Optional rx glitch filter: define UART_RX_GLITCH_FILTER_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      valid,
    output logic                      busy,
    output logic                      frame_err
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    logic                      w_rxs;
    logic [1:0]                r_state,     w_state_nxt;
    logic [CNT_W-1:0]          r_clk_cnt,   w_clk_cnt_nxt;
    logic [BIT_W-1:0]          r_bit_cnt,   w_bit_cnt_nxt;
    logic [UART_DATA_BITS-1:0] r_shift,     w_shift_nxt;
    logic [UART_DATA_BITS-1:0] r_data_out,  w_data_out_nxt;
    logic                      r_valid,     w_valid_nxt;
    logic                      r_busy,      w_busy_nxt;
    logic                      r_frame_err, w_frame_err_nxt;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_rx    (rx),
        .o_rxs_c (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_data_out  <= w_data_out_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state and registered-output logic; strobes default low every cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_clk_cnt_nxt   = r_clk_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_data_out_nxt  = r_data_out;
        w_valid_nxt     = 1'b0;
        w_busy_nxt      = r_busy;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (!w_rxs) begin
                    w_state_nxt   = ST_START;
                    w_clk_cnt_nxt = '0;
                    w_busy_nxt    = 1'b1;
                end
            end
            ST_START: begin
                if (r_clk_cnt == HALF_LAST) begin
                    w_clk_cnt_nxt = '0;
                    if (!w_rxs) begin
                        w_state_nxt   = ST_DATA;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_clk_cnt == FULL_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {w_rxs, r_shift[UART_DATA_BITS-1:1]};
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is seen from IDLE.
                if (r_clk_cnt == FULL_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                    w_busy_nxt    = 1'b0;
                    if (w_rxs) begin
                        w_data_out_nxt = r_shift;
                        w_valid_nxt    = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign data_out  = r_data_out;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx at BAUD_DIV=16; a frame-level model predicts
// the received byte stream, frame-error count and held data_out.
module tb_uart_rx;

    localparam int unsigned BD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] got_q[$];
    int         n_fe   = 0;
    int         n_both = 0;
    logic       busy_seen = 1'b0;

    logic [7:0] exp_q[$];
    int         exp_fe    = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(.BAUD_DIV(BD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Observe strobes on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) got_q.push_back(data_out);
            if (frame_err) n_fe++;
            if (valid && frame_err) n_both++;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BD) @(negedge clk);
    endtask

    // Transmitter model: start bit, 8 data bits LSB first, stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (stop_ok) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    task automatic scoreboard(input string tag);
        int n;
        chk({tag, " nvalid"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, " byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, " nframe_err"}, 32'(n_fe), 32'(exp_fe));
        chk({tag, " data_out"}, 32'(data_out), 32'(last_good));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(100);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset data_out", 32'(data_out), 32'h00);

        send_frame(8'hA5, 1'b1);
        idle(4);
        wait_idle("a5", 200);
        scoreboard("a5");

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(4);
        wait_idle("b2b", 200);
        scoreboard("b2b");

        send_frame(8'h55, 1'b0);
        idle(30);
        wait_idle("stoplow", 200);
        scoreboard("stoplow");

        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        chk("glitch4 busy_seen", 32'(busy_seen), 32'd1);
        wait_idle("glitch4", 50);
        scoreboard("glitch4");

`ifdef UART_RX_GLITCH_FILTER_EN
        busy_seen = 1'b0;
        rx = 1'b0;
        @(negedge clk);
        idle(40);
        chk("glitch1 busy_seen", 32'(busy_seen), 32'd0);
        scoreboard("glitch1");
`endif

        // Break of 310 cycles: stop samples at ~152 and ~305 land low, the third start check sees high.
        rx = 1'b0;
        repeat (310) @(negedge clk);
        exp_fe += 2;
        idle(200);
        wait_idle("break", 200);
        scoreboard("break");

        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rx    = 1'b1;
        rst_n = 1'b1;
        last_good = 8'h00;
        idle(40);
        chk("rstmid busy", 32'(busy), 32'd0);
        scoreboard("rstmid");
        send_frame(8'h81, 1'b1);
        idle(4);
        wait_idle("81", 200);
        scoreboard("81");

        // Randomized frames with occasional low stop bits and random idle gaps.
        for (int k = 0; k < 30; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(b, ok);
            chk("rand data_out", 32'(data_out), 32'(last_good));
            idle(ok ? $urandom_range(0, 12) : 20);
        end
        idle(20);
        wait_idle("rand", 200);
        scoreboard("rand");
        chk("valid_and_frame_err", 32'(n_both), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
